// File: rtl/soc2_sysid_checker.sv
// soc2_sysid_checker: reads the sysid ID/timestamp words, compares them to build-time values; done START_DELAY+3 edges after reset (zero-wait).
// Holds each read across avm_waitrequest indefinitely, unless SYSID_CHECK_TIMEOUT_EN bounds each read to TIMEOUT_CYCLES stall cycles.
module soc2_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1730382246,
  parameter int          START_DELAY        = 16,
  parameter int          MAX_ATTEMPTS       = 3,
  parameter int          TIMEOUT_CYCLES     = 256
) (
  input  logic        clock,
  input  logic        reset,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        recheck,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [1:0]  attempts
);

  typedef enum logic [2:0] {
    S_DELAY,
    S_RD_ID,
    S_RD_TS,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_t;

  localparam logic [15:0] DLY_LAST = (START_DELAY > 0) ? 16'(START_DELAY - 1) : 16'd0;

  state_t      state, state_nxt;
  logic [15:0] dly_cnt;
  logic [7:0]  try_cnt;
  logic        delay_done;
  logic        id_bad, ts_bad;
  logic        retry_ok;
  logic        rd_stall;
  logic        to_expire;

  assign delay_done = (START_DELAY == 0) || (dly_cnt == DLY_LAST);
  assign id_bad     = (id_value != EXPECTED_ID);
  assign ts_bad     = (ts_value != EXPECTED_TIMESTAMP);
  // Internal count is wider than the 2-bit output so retries stay bounded for MAX_ATTEMPTS > 4.
  assign retry_ok   = (({24'd0, try_cnt} + 32'd1) < 32'(MAX_ATTEMPTS));
  assign rd_stall   = avm_read && avm_waitrequest;

`ifdef SYSID_CHECK_TIMEOUT_EN
  logic [31:0] to_cnt;

  assign to_expire = rd_stall && (to_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (rd_stall && !to_expire) begin
      to_cnt <= to_cnt + 32'd1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  // Never true: without the timeout option the master waits on waitrequest forever.
  assign to_expire = rd_stall && (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_nxt   = state;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    case (state)
      S_DELAY: begin
        if (delay_done) state_nxt = S_RD_ID;
      end
      S_RD_ID: begin
        avm_read = 1'b1;
        if (!avm_waitrequest)  state_nxt = S_RD_TS;
        else if (to_expire)    state_nxt = S_FAIL;
      end
      S_RD_TS: begin
        avm_read    = 1'b1;
        avm_address = 1'b1;
        if (!avm_waitrequest)  state_nxt = S_CHECK;
        else if (to_expire)    state_nxt = S_FAIL;
      end
      S_CHECK: begin
        if (!id_bad && !ts_bad) state_nxt = S_PASS;
        else if (retry_ok)      state_nxt = S_DELAY;
        else                    state_nxt = S_FAIL;
      end
      S_PASS, S_FAIL: begin
        if (recheck) state_nxt = S_DELAY;
      end
      default: state_nxt = S_DELAY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_DELAY;
      dly_cnt     <= '0;
      try_cnt     <= '0;
      id_value    <= '0;
      ts_value    <= '0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == S_DELAY && state_nxt == S_DELAY) dly_cnt <= dly_cnt + 16'd1;
      else                                          dly_cnt <= '0;

      if (state == S_RD_ID && !avm_waitrequest) id_value <= avm_readdata;
      if (state == S_RD_TS && !avm_waitrequest) ts_value <= avm_readdata;

      if (to_expire) timeout <= 1'b1;

      if (state == S_CHECK) begin
        id_mismatch <= id_bad;
        ts_mismatch <= ts_bad;
        if ((id_bad || ts_bad) && try_cnt != 8'hFF) try_cnt <= try_cnt + 8'd1;
      end

      if ((state == S_PASS || state == S_FAIL) && recheck) begin
        try_cnt     <= '0;
        id_mismatch <= 1'b0;
        ts_mismatch <= 1'b0;
        timeout     <= 1'b0;
      end
    end
  end

  assign done     = (state == S_PASS) || (state == S_FAIL);
  assign pass     = (state == S_PASS);
  assign attempts = (try_cnt > 8'd3) ? 2'd3 : try_cnt[1:0];

endmodule
